// File: rtl/flop_stim_checker.sv
// flop_stim_checker: LFSR stimulus for a sync/async DFF pair, with an in-hardware reference check of both q outputs
module flop_stim_checker #(
  parameter int          NUM_VEC = 16,
  parameter logic [7:0]  SEED    = 8'hA5,
  parameter int          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_d,
  output logic             dut_rst_n,
  input  logic             q_syn,
  input  logic             q_asyn,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] vec_idx
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [7:0] LOAD = (SEED == 8'h00) ? 8'h01 : SEED;
  state_t state, nxt;
  logic [7:0] lfsr;
  logic drn, go, last, fb, exp_syn, exp_asyn;
  logic [2:0] p0, p1;
  logic [1:0] e;
  logic [CNT_W:0] sum;
  always_comb begin
    go = start && (state == IDLE || state == DONE);
    last = vec_idx == CNT_W'(NUM_VEC - 1);
    nxt = go ? RUN : (state == RUN && last) ? DRAIN : (state == DRAIN && drn) ? DONE : state;
    fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    exp_syn = p1[0] & p1[1];
    // async flop is cleared mid-cycle when the following vector asserts reset
    exp_asyn = p0[0] & exp_syn;
    e = 2'(q_syn !== exp_syn) + 2'(q_asyn !== exp_asyn);
    sum = {1'b0, err_cnt} + (CNT_W+1)'(e);
  end
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  assign pass = done && err_cnt == '0;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  // pipeline entries are {valid, d, r}; drain slots carry r=1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= LOAD;
      drn <= 1'b0;
      p0 <= '0;
      p1 <= '0;
      err_cnt <= '0;
      vec_idx <= '0;
      dut_d <= 1'b0;
      dut_rst_n <= 1'b0;
    end else begin
      p0 <= (state == RUN) ? {1'b1, lfsr[0], |lfsr[7:5]} : 3'b001;
      p1 <= p0;
      drn <= state == DRAIN && !drn;
      if (p1[2]) err_cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      if (go) begin
        lfsr <= LOAD;
        err_cnt <= '0;
        vec_idx <= '0;
        dut_d <= 1'b0;
        dut_rst_n <= 1'b0;
      end else if (state == RUN) begin
        lfsr <= {lfsr[6:0], fb};
        vec_idx <= vec_idx + CNT_W'(1);
        dut_d <= lfsr[0];
        dut_rst_n <= |lfsr[7:5];
      end else begin
        dut_d <= 1'b0;
        dut_rst_n <= state == DRAIN && !drn;
      end
    end
  end
endmodule

// File: tb/tb_flop_stim_checker.sv
// tb_flop_stim_checker: directed runs of three checker instances driving behavioural sync/async DFFs
module tb_flop_stim_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] go = '0;
  int mode = 0;
  int total = 0;
  int bad = 0;
  logic [2:0] dd, dr, bz, dn, ps;
  logic [7:0] ec_a, ec_b, vi_a, vi_b;
  logic [2:0] ec_c, vi_c;
  logic [2:0] fs = '0;
  logic fa0 = 1'b0, fa1 = 1'b0, fa2 = 1'b0;
  logic qs_a, qa_a, qs_b, qa_b, qs_c, qa_c;
  logic md [0:63];
  logic mr [0:64];
  logic [63:0] dseq;

  always #5 clk = ~clk;

  always @(posedge clk) fs <= dr & dd;
  always @(posedge clk or negedge dr[0]) if (!dr[0]) fa0 <= 1'b0; else fa0 <= dd[0];
  always @(posedge clk or negedge dr[1]) if (!dr[1]) fa1 <= 1'b0; else fa1 <= dd[1];
  always @(posedge clk or negedge dr[2]) if (!dr[2]) fa2 <= 1'b0; else fa2 <= dd[2];

  // mode 1: q_syn stuck at 0; mode 2: q_asyn comes from a sync-reset flop
  assign qs_a = (mode == 1) ? 1'b0 : fs[0];
  assign qa_a = (mode == 2) ? fs[0] : fa0;
  assign qs_b = (mode == 1) ? 1'b0 : fs[1];
  assign qa_b = (mode == 2) ? fs[1] : fa1;
  assign qs_c = ~fs[2];
  assign qa_c = ~fa2;

  flop_stim_checker #(.NUM_VEC(16), .SEED(8'hA5), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(go[0]), .dut_d(dd[0]), .dut_rst_n(dr[0]),
    .q_syn(qs_a), .q_asyn(qa_a), .busy(bz[0]), .done(dn[0]), .pass(ps[0]),
    .err_cnt(ec_a), .vec_idx(vi_a));
  flop_stim_checker #(.NUM_VEC(20), .SEED(8'h00), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(go[1]), .dut_d(dd[1]), .dut_rst_n(dr[1]),
    .q_syn(qs_b), .q_asyn(qa_b), .busy(bz[1]), .done(dn[1]), .pass(ps[1]),
    .err_cnt(ec_b), .vec_idx(vi_b));
  flop_stim_checker #(.NUM_VEC(7), .SEED(8'hA5), .CNT_W(3)) u_c (
    .clk(clk), .rst_n(rst_n), .start(go[2]), .dut_d(dd[2]), .dut_rst_n(dr[2]),
    .q_syn(qs_c), .q_asyn(qa_c), .busy(bz[2]), .done(dn[2]), .pass(ps[2]),
    .err_cnt(ec_c), .vec_idx(vi_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic sample(input int i, output logic [31:0] drv, output logic [31:0] st,
                        output logic [31:0] err, output logic [31:0] idx);
    drv = {30'd0, dd[i], dr[i]};
    st = {29'd0, bz[i], dn[i], ps[i]};
    err = (i == 0) ? {24'd0, ec_a} : (i == 1) ? {24'd0, ec_b} : {29'd0, ec_c};
    idx = (i == 0) ? {24'd0, vi_a} : (i == 1) ? {24'd0, vi_b} : {29'd0, vi_c};
  endtask

  task automatic gen(input logic [7:0] seed, input int n);
    logic [7:0] l;
    l = (seed == 8'h00) ? 8'h01 : seed;
    for (int k = 0; k < n; k++) begin
      md[k] = l[0];
      mr[k] = |l[7:5];
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    mr[n] = 1'b1;
  endtask

  function automatic int count(input int m, input int n);
    int c;
    c = 0;
    for (int k = 0; k < n; k++)
      c += (m == 1) ? int'(mr[k] & md[k]) : int'(!mr[k+1] & mr[k] & md[k]);
    return c;
  endfunction

  // call at a negedge; the next posedge samples start
  task automatic run(input int i, input logic [31:0] exp_err, input bit hold, output logic [63:0] seq);
    int n;
    logic [31:0] a, b, c, v;
    n = (i == 0) ? 16 : (i == 1) ? 20 : 7;
    gen((i == 1) ? 8'h00 : 8'hA5, n);
    seq = '0;
    go[i] = 1'b1;
    @(negedge clk);
    if (!hold) go[i] = 1'b0;
    sample(i, a, b, c, v);
    check("start_status", b, 32'b100);
    check("start_drive", a, 0);
    check("start_err", c, 0);
    check("start_idx", v, 0);
    for (int cyc = 1; cyc <= n + 2; cyc++) begin
      @(negedge clk);
      sample(i, a, b, c, v);
      if (cyc <= n) seq[cyc-1] = a[1];
      check("drive", a, (cyc <= n) ? {30'd0, md[cyc-1], mr[cyc-1]} : (cyc == n + 1) ? 32'b01 : 32'b00);
      check("done_timing", {31'd0, b[1]}, (cyc == n + 2) ? 1 : 0);
    end
    check("err_cnt", c, exp_err);
    check("pass", {31'd0, b[0]}, (exp_err == 0) ? 1 : 0);
    check("busy_end", {31'd0, b[2]}, 0);
    check("idx_end", v, n);
  endtask

  initial begin
    logic [31:0] a, b, c, v;
    logic seen;
    int eb;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sample(i, a, b, c, v);
      check("rst_drive", a, 0);
      check("rst_status", b, 0);
      check("rst_err", c, 0);
      check("rst_idx", v, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 0, 0, dseq);
    check("golden_dseq", {16'd0, dseq[15:0]}, 32'h6EE5);
    run(1, 0, 0, dseq);
    mode = 1;
    run(0, 10, 0, dseq);
    gen(8'h00, 20);
    eb = count(1, 20);
    run(1, eb, 0, dseq);
    mode = 2;
    run(0, 0, 0, dseq);
    gen(8'h00, 20);
    eb = count(2, 20);
    check("b_async_faults_exist", {31'd0, eb > 0}, 1);
    run(1, eb, 0, dseq);
    mode = 0;
    go[0] = 1'b1;
    @(negedge clk);
    go[0] = 1'b0;
    repeat (5) @(negedge clk);
    sample(0, a, b, c, v);
    check("abort_pre_idx", v, 5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sample(0, a, b, c, v);
    check("abort_status", b, 0);
    check("abort_err", c, 0);
    check("abort_idx", v, 0);
    check("abort_drive", a, 0);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen |= dn[0];
    end
    check("abort_no_done", {31'd0, seen}, 0);
    run(0, 0, 0, dseq);
    check("rerun_dseq", {16'd0, dseq[15:0]}, 32'h6EE5);
    run(2, 7, 1, dseq);
    check("sat_dseq1", {25'd0, dseq[6:0]}, 32'h65);
    run(2, 7, 1, dseq);
    check("sat_dseq2", {25'd0, dseq[6:0]}, 32'h65);
    go[2] = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
